// File: rtl/keypad_entry.sv
// 4x4 matrix keypad scanner with press/release debounce and a 3-digit BCD entry register.
// Digit keys shift in, '*' clears, '#' converts the digits to a saturated 8-bit value.
module keypad_entry #(
  parameter logic [24:0] SCAN_DIV       = 25'd49_999,
  parameter logic [4:0]  DEBOUNCE_SCANS = 5'd20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  rows,
  output logic [3:0]  cols,
  output logic        key_valid,
  output logic [3:0]  key_code,
  output logic [11:0] digits,
  output logic [7:0]  value,
  output logic        value_valid,
  output logic        ovf
);

  typedef enum logic [1:0] {S_SCAN, S_DEBOUNCE, S_PRESSED, S_RELEASE} state_t;

  localparam logic [4:0] CNT_LAST  = DEBOUNCE_SCANS - 5'd1;
  localparam logic [3:0] CODE_STAR = 4'd12;
  localparam logic [3:0] CODE_HASH = 4'd14;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [3:0]  r_sync1;
  logic [3:0]  r_sync2;
  logic [24:0] r_div;
  logic [4:0]  r_cnt;
  logic [4:0]  w_cnt_nxt;
  logic [1:0]  r_col;
  logic [1:0]  w_col_nxt;
  logic [1:0]  r_row;
  logic [1:0]  w_row_nxt;
  logic [1:0]  w_low_row;
  logic        w_tick;
  logic        w_rows_idle;
  logic        w_accept;
  logic [3:0]  w_code;
  logic        w_is_digit;
  logic [3:0]  w_digit;
  logic [9:0]  w_bin;

  logic        r_key_valid;
  logic [3:0]  r_key_code;
  logic [11:0] r_digits;
  logic [7:0]  r_value;
  logic        r_value_valid;
  logic        r_ovf;

  // rows are asynchronous to clk; only r_sync2 is ever looked at
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1 <= 4'b1111;
      r_sync2 <= 4'b1111;
    end else begin
      r_sync1 <= rows;
      r_sync2 <= r_sync1;
    end
  end

  assign w_tick      = (r_div == SCAN_DIV);
  assign w_rows_idle = &r_sync2;
  assign w_code      = {r_row, r_col};

  always_comb begin
    w_low_row = 2'd3;
    if (!r_sync2[0])      w_low_row = 2'd0;
    else if (!r_sync2[1]) w_low_row = 2'd1;
    else if (!r_sync2[2]) w_low_row = 2'd2;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_col_nxt   = r_col;
    w_row_nxt   = r_row;
    w_accept    = 1'b0;
    case (r_state)
      S_SCAN: begin
        if (w_tick) begin
          if (w_rows_idle) begin
            w_col_nxt = r_col + 2'd1;
          end else begin
            w_row_nxt   = w_low_row;
            w_cnt_nxt   = 5'd0;
            w_state_nxt = S_DEBOUNCE;
          end
        end
      end
      S_DEBOUNCE: begin
        if (w_tick) begin
          if (!r_sync2[r_row]) begin
            if (r_cnt == CNT_LAST) begin
              w_accept    = 1'b1;
              w_state_nxt = S_PRESSED;
            end else begin
              w_cnt_nxt = r_cnt + 5'd1;
            end
          end else begin
            w_cnt_nxt   = 5'd0;
            w_state_nxt = S_SCAN;
          end
        end
      end
      S_PRESSED: begin
        w_cnt_nxt   = 5'd0;
        w_state_nxt = S_RELEASE;
      end
      S_RELEASE: begin
        if (w_tick) begin
          if (!w_rows_idle) begin
            w_cnt_nxt = 5'd0;
          end else if (r_cnt == CNT_LAST) begin
            w_cnt_nxt   = 5'd0;
            w_col_nxt   = r_col + 2'd1;
            w_state_nxt = S_SCAN;
          end else begin
            w_cnt_nxt = r_cnt + 5'd1;
          end
        end
      end
      default: w_state_nxt = S_SCAN;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_SCAN;
      r_div   <= 25'd0;
      r_cnt   <= 5'd0;
      r_col   <= 2'd0;
      r_row   <= 2'd0;
    end else begin
      r_state <= w_state_nxt;
      r_div   <= w_tick ? 25'd0 : r_div + 25'd1;
      r_cnt   <= w_cnt_nxt;
      r_col   <= w_col_nxt;
      r_row   <= w_row_nxt;
    end
  end

  // keypad layout: row-major 1 2 3 A / 4 5 6 B / 7 8 9 C / * 0 # D
  always_comb begin
    w_is_digit = 1'b1;
    w_digit    = 4'd0;
    case (w_code)
      4'd0:    w_digit = 4'd1;
      4'd1:    w_digit = 4'd2;
      4'd2:    w_digit = 4'd3;
      4'd4:    w_digit = 4'd4;
      4'd5:    w_digit = 4'd5;
      4'd6:    w_digit = 4'd6;
      4'd8:    w_digit = 4'd7;
      4'd9:    w_digit = 4'd8;
      4'd10:   w_digit = 4'd9;
      4'd13:   w_digit = 4'd0;
      default: w_is_digit = 1'b0;
    endcase
  end

  assign w_bin = 10'(r_digits[11:8]) * 10'd100
               + 10'(r_digits[7:4])  * 10'd10
               + 10'(r_digits[3:0]);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_key_valid   <= 1'b0;
      r_key_code    <= 4'd0;
      r_digits      <= 12'd0;
      r_value       <= 8'd0;
      r_value_valid <= 1'b0;
      r_ovf         <= 1'b0;
    end else begin
      r_key_valid   <= w_accept;
      r_value_valid <= 1'b0;
      if (w_accept) begin
        r_key_code <= w_code;
        if (w_is_digit) begin
          r_digits <= {r_digits[7:0], w_digit};
        end else if (w_code == CODE_STAR) begin
          r_digits <= 12'd0;
          r_ovf    <= 1'b0;
        end else if (w_code == CODE_HASH) begin
          r_value       <= (w_bin > 10'd255) ? 8'd255 : w_bin[7:0];
          r_ovf         <= (w_bin > 10'd255);
          r_value_valid <= 1'b1;
        end
      end
    end
  end

  assign cols        = ~(4'b0001 << r_col);
  assign key_valid   = r_key_valid;
  assign key_code    = r_key_code;
  assign digits      = r_digits;
  assign value       = r_value;
  assign value_valid = r_value_valid;
  assign ovf         = r_ovf;

endmodule
